// File: rtl/rx_word_aligner.sv
// 8b/10b word aligner: finds the K28.5 comma boundary in the recovered bit stream,
// qualifies it through a SEARCH/VERIFY/LOCKED FSM and emits aligned 10-bit code groups.
module rx_word_aligner #(
    parameter int unsigned LOCK_COMMAS = 2,
    parameter int unsigned MISS_LIMIT  = 3
) (
    input  logic       BitCLK,
    input  logic       Reset,
    input  logic       Dn,
    output logic [9:0] word_out,
    output logic       word_valid,
    output logic       comma_det,
    output logic       aligned,
    output logic [7:0] slip_cnt
);

    localparam logic [9:0]  K28_5_RDN = 10'h17C;
    localparam logic [9:0]  K28_5_RDP = 10'h283;
    localparam int unsigned HITS_W    = $clog2(LOCK_COMMAS + 1);
    localparam int unsigned MISS_W    = $clog2(MISS_LIMIT + 1);

    localparam logic [HITS_W-1:0] HITS_ONE  = HITS_W'(1);
    localparam logic [HITS_W-1:0] HITS_LOCK = HITS_W'(LOCK_COMMAS);
    localparam logic [MISS_W-1:0] MISS_ONE  = MISS_W'(1);
    localparam logic [MISS_W-1:0] MISS_LIM  = MISS_W'(MISS_LIMIT);
    localparam logic [MISS_W-1:0] MISS_ZERO = MISS_W'(0);
    localparam logic [3:0]        CNT_LAST  = 4'd9;
    localparam logic [7:0]        SLIP_MAX  = 8'd255;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    function automatic logic is_k28_5(input logic [9:0] grp);
        return (grp == K28_5_RDN) || (grp == K28_5_RDP);
    endfunction

    state_t              state_q, state_d;
    logic [9:0]          sr_q;
    logic [9:0]          sr_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [HITS_W-1:0]   hits_q, hits_d;
    logic [MISS_W-1:0]   miss_cnt_q, miss_cnt_d;
    logic [9:0]          word_out_q, word_out_d;
    logic                word_valid_q, word_valid_d;
    logic                comma_det_q, comma_det_d;
    logic                aligned_q, aligned_d;
    logic [7:0]          slip_cnt_q, slip_cnt_d;

    logic                comma_hit_s;
    logic                boundary_s;
    logic                capture_s;
    logic [HITS_W-1:0]   hits_inc_s;
    logic [MISS_W-1:0]   miss_inc_s;

    // Datapath view of this edge: incoming window, comma match and boundary phase.
    always_comb begin
        sr_d        = {Dn, sr_q[9:1]};
        comma_hit_s = is_k28_5(sr_d);
        boundary_s  = (bit_cnt_q == CNT_LAST);
        hits_inc_s  = hits_q + HITS_ONE;
        miss_inc_s  = miss_cnt_q + MISS_ONE;
    end

    // Lock FSM next-state, capture decision and counter updates.
    always_comb begin
        state_d    = state_q;
        hits_d     = hits_q;
        miss_cnt_d = miss_cnt_q;
        slip_cnt_d = slip_cnt_q;
        capture_s  = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                if (comma_hit_s) begin
                    capture_s  = 1'b1;
                    hits_d     = HITS_ONE;
                    miss_cnt_d = MISS_ZERO;
                    if (HITS_ONE == HITS_LOCK) begin
                        state_d = ST_LOCKED;
                    end else begin
                        state_d = ST_VERIFY;
                    end
                end else begin
                    state_d = ST_SEARCH;
                end
            end
            ST_VERIFY: begin
                if (boundary_s) begin
                    capture_s = 1'b1;
                    if (comma_hit_s) begin
                        hits_d = hits_inc_s;
                        if (hits_inc_s == HITS_LOCK) begin
                            state_d    = ST_LOCKED;
                            miss_cnt_d = MISS_ZERO;
                        end else begin
                            state_d = ST_VERIFY;
                        end
                    end else begin
                        hits_d = hits_q;
                    end
                end else if (comma_hit_s) begin
                    // Comma at a new phase: move the boundary onto it right away.
                    capture_s = 1'b1;
                    hits_d    = HITS_ONE;
                end else begin
                    capture_s = 1'b0;
                end
            end
            ST_LOCKED: begin
                if (boundary_s) begin
                    capture_s = 1'b1;
                    if (comma_hit_s) begin
                        miss_cnt_d = MISS_ZERO;
                    end else begin
                        miss_cnt_d = miss_cnt_q;
                    end
                end else if (comma_hit_s) begin
                    if (miss_inc_s == MISS_LIM) begin
                        state_d    = ST_SEARCH;
                        miss_cnt_d = MISS_ZERO;
                        if (slip_cnt_q == SLIP_MAX) begin
                            slip_cnt_d = SLIP_MAX;
                        end else begin
                            slip_cnt_d = slip_cnt_q + 8'd1;
                        end
                    end else begin
                        miss_cnt_d = miss_inc_s;
                    end
                end else begin
                    capture_s = 1'b0;
                end
            end
            default: begin
                state_d    = ST_SEARCH;
                hits_d     = '0;
                miss_cnt_d = MISS_ZERO;
            end
        endcase
    end

    // Output register next values and bit phase counter.
    always_comb begin
        if (capture_s || boundary_s) begin
            bit_cnt_d = 4'd0;
        end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
        end
        if (capture_s) begin
            word_out_d = sr_d;
        end else begin
            word_out_d = word_out_q;
        end
        word_valid_d = capture_s;
        comma_det_d  = capture_s & comma_hit_s;
        aligned_d    = (state_d == ST_LOCKED);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge BitCLK) begin
        if (Reset) begin
            state_q      <= ST_SEARCH;
            sr_q         <= 10'd0;
            bit_cnt_q    <= 4'd0;
            hits_q       <= '0;
            miss_cnt_q   <= '0;
            word_out_q   <= 10'd0;
            word_valid_q <= 1'b0;
            comma_det_q  <= 1'b0;
            aligned_q    <= 1'b0;
            slip_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            hits_q       <= hits_d;
            miss_cnt_q   <= miss_cnt_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
            comma_det_q  <= comma_det_d;
            aligned_q    <= aligned_d;
            slip_cnt_q   <= slip_cnt_d;
        end
    end

    assign word_out   = word_out_q;
    assign word_valid = word_valid_q;
    assign comma_det  = comma_det_q;
    assign aligned    = aligned_q;
    assign slip_cnt   = slip_cnt_q;

endmodule

// File: tb/tb_rx_word_aligner.sv
// Bench for rx_word_aligner: directed lock scenarios plus randomized traffic, every
// cycle compared against a bit-history / phase-arithmetic reference model.
module tb_rx_word_aligner;

    localparam int LOCK_COMMAS = 2;
    localparam int MISS_LIMIT  = 3;
    localparam int M_SEARCH = 0;
    localparam int M_VERIFY = 1;
    localparam int M_LOCKED = 2;
    localparam logic [9:0] C_RDN = 10'h17C;
    localparam logic [9:0] C_RDP = 10'h283;

    logic       BitCLK;
    logic       Reset;
    logic       Dn;
    logic [9:0] word_out;
    logic       word_valid;
    logic       comma_det;
    logic       aligned;
    logic [7:0] slip_cnt;

    int n_checks;
    int n_fail;

    // reference model state
    bit         hist[$];
    int         t_now;
    int         anchor;
    int         m_mode;
    int         m_hits;
    int         m_miss;
    int         m_slip;
    logic [9:0] m_word;
    bit         m_valid;
    bit         m_comma;
    bit         m_aligned;

    rx_word_aligner #(
        .LOCK_COMMAS(LOCK_COMMAS),
        .MISS_LIMIT (MISS_LIMIT)
    ) dut (
        .BitCLK    (BitCLK),
        .Reset     (Reset),
        .Dn        (Dn),
        .word_out  (word_out),
        .word_valid(word_valid),
        .comma_det (comma_det),
        .aligned   (aligned),
        .slip_cnt  (slip_cnt)
    );

    initial BitCLK = 1'b0;
    always #5 BitCLK = ~BitCLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [9:0] last_ten();
        logic [9:0] w;
        int n;
        w = 10'd0;
        n = hist.size();
        for (int i = 0; i < 10; i++) begin
            if (n - 10 + i >= 0) w[i] = hist[n - 10 + i];
        end
        return w;
    endfunction

    // One clock edge of the reference behaviour.
    task automatic model_edge(input bit rst, input bit d);
        logic [9:0] win;
        bit hit, on_bnd, cap;
        t_now++;
        if (rst) begin
            hist.delete();
            m_mode = M_SEARCH; m_hits = 0; m_miss = 0; m_slip = 0;
            m_word = 10'd0; m_valid = 1'b0; m_comma = 1'b0; m_aligned = 1'b0;
            anchor = t_now;
            return;
        end
        hist.push_back(d);
        if (hist.size() > 10) void'(hist.pop_front());
        win    = last_ten();
        hit    = (win == C_RDN) || (win == C_RDP);
        on_bnd = ((t_now - anchor) % 10 == 0) && (t_now != anchor);
        cap    = 1'b0;
        if (m_mode == M_SEARCH) begin
            if (hit) begin
                cap = 1'b1; m_hits = 1; m_miss = 0;
                m_mode = (LOCK_COMMAS == 1) ? M_LOCKED : M_VERIFY;
            end
        end else if (m_mode == M_VERIFY) begin
            if (on_bnd) begin
                cap = 1'b1;
                if (hit) begin
                    m_hits++;
                    if (m_hits >= LOCK_COMMAS) begin m_mode = M_LOCKED; m_miss = 0; end
                end
            end else if (hit) begin
                cap = 1'b1; m_hits = 1;
            end
        end else begin
            if (on_bnd) begin
                cap = 1'b1;
                if (hit) m_miss = 0;
            end else if (hit) begin
                m_miss++;
                if (m_miss >= MISS_LIMIT) begin
                    m_mode = M_SEARCH; m_miss = 0;
                    if (m_slip < 255) m_slip++;
                end
            end
        end
        if (cap) begin
            anchor = t_now;
            m_word = win;
        end
        m_valid   = cap;
        m_comma   = cap && hit;
        m_aligned = (m_mode == M_LOCKED);
    endtask

    task automatic step(input bit rst, input bit d);
        Reset = rst;
        Dn    = d;
        @(posedge BitCLK);
        model_edge(rst, d);
        #1;
        check_eq("word_valid", 32'(word_valid), 32'(m_valid));
        check_eq("comma_det",  32'(comma_det),  32'(m_comma));
        check_eq("word_out",   32'(word_out),   32'(m_word));
        check_eq("aligned",    32'(aligned),    32'(m_aligned));
        check_eq("slip_cnt",   32'(slip_cnt),   32'(m_slip));
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int i = 0; i < 10; i++) step(1'b0, w[i]);
    endtask

    task automatic expect_out(input string tag, input bit v, input bit c, input bit a);
        check_eq({tag, "_valid"},   32'(word_valid), 32'(v));
        check_eq({tag, "_comma"},   32'(comma_det),  32'(c));
        check_eq({tag, "_aligned"}, 32'(aligned),    32'(a));
    endtask

    task automatic expect_all_zero(input string tag);
        check_eq({tag, "_word"},  32'(word_out), 32'd0);
        check_eq({tag, "_slip"},  32'(slip_cnt), 32'd0);
        expect_out(tag, 1'b0, 1'b0, 1'b0);
    endtask

    // Lock is held; one extra bit then five commas: three misses, then reacquire.
    task automatic lose_and_relock(input int exp_slip);
        step(1'b0, 1'b0);
        send_word(C_RDN); expect_out("miss1", 1'b0, 1'b0, 1'b1);
        send_word(C_RDN); expect_out("miss2", 1'b0, 1'b0, 1'b1);
        send_word(C_RDN); expect_out("miss3", 1'b0, 1'b0, 1'b0);
        check_eq("slip_after_loss", 32'(slip_cnt), 32'(exp_slip));
        send_word(C_RDN); expect_out("reacq1", 1'b1, 1'b1, 1'b0);
        check_eq("reacq1_word", 32'(word_out), 32'(C_RDN));
        send_word(C_RDN); expect_out("reacq2", 1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        int vcount;
        n_checks = 0;
        n_fail   = 0;
        t_now    = 0;
        anchor   = 0;
        Reset    = 1'b1;
        Dn       = 1'b0;

        // reset with toggling data, then idle
        for (int i = 0; i < 3; i++) step(1'b1, 1'(i));
        expect_all_zero("reset");
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0);
            if (word_valid) vcount++;
        end
        check_eq("idle_no_valid", 32'(vcount), 32'd0);
        expect_all_zero("idle");

        // acquire
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        send_word(C_RDN);
        expect_out("acq1", 1'b1, 1'b1, 1'b0);
        check_eq("acq1_word", 32'(word_out), 32'(C_RDN));
        send_word(C_RDN);
        expect_out("acq2", 1'b1, 1'b1, 1'b1);

        // data while locked
        send_word(10'h2AA);
        expect_out("data", 1'b1, 1'b0, 1'b1);
        check_eq("data_word", 32'(word_out), 32'h2AA);
        send_word(C_RDP);
        expect_out("rdp", 1'b1, 1'b1, 1'b1);
        check_eq("rdp_word", 32'(word_out), 32'(C_RDP));

        // lock loss twice
        lose_and_relock(1);
        lose_and_relock(2);

        // mid-operation reset
        step(1'b1, 1'b1);
        expect_all_zero("midreset");
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        send_word(C_RDN); expect_out("racq1", 1'b1, 1'b1, 1'b0);
        send_word(C_RDN); expect_out("racq2", 1'b1, 1'b1, 1'b1);

        // VERIFY realign by 4 bits
        step(1'b1, 1'b0);
        send_word(C_RDN); expect_out("ver1", 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        send_word(C_RDN); expect_out("realign", 1'b1, 1'b1, 1'b0);
        send_word(C_RDN); expect_out("relock", 1'b1, 1'b1, 1'b1);

        // slip counter saturation
        for (int k = 0; k < 260; k++) begin
            step(1'b0, 1'b0);
            for (int j = 0; j < 5; j++) send_word(C_RDN);
        end
        check_eq("slip_sat", 32'(slip_cnt), 32'd255);
        check_eq("slip_sat_aligned", 32'(aligned), 32'd1);

        // randomized traffic
        for (int it = 0; it < 600; it++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel <= 3) begin
                send_word(10'($urandom));
            end else if (sel <= 6) begin
                send_word(($urandom_range(0, 1) == 0) ? C_RDN : C_RDP);
            end else if (sel <= 8) begin
                int g;
                g = $urandom_range(1, 9);
                for (int i = 0; i < g; i++) step(1'b0, 1'($urandom));
            end else if ($urandom_range(0, 9) == 0) begin
                step(1'b1, 1'($urandom));
            end else begin
                send_word(C_RDN);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
